// File: rtl/uart_tx.sv
// UART transmitter: start bit, N_DATA data bits LSB first, optional parity, M_STOP stop bits.
// Each bit spans TICKS_PER_BIT baud ticks; o_tx/o_busy/o_tx_done are registered, starts while busy are dropped.
module uart_tx #(
   parameter int N_DATA          = 8,
   parameter int PARITY_CHECK    = 0,
   parameter int EVEN_ODD_PARITY = 1,
   parameter int M_STOP          = 1,
   parameter int TICKS_PER_BIT   = 16
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_tick,
   input  logic              i_tx_start,
   input  logic [N_DATA-1:0] i_data,
   output logic              o_tx,
   output logic              o_busy,
   output logic              o_tx_done
);

   localparam int TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
   localparam int BIT_W  = (N_DATA > 1) ? $clog2(N_DATA) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N_DATA - 1);
   localparam logic              STOP_LAST = 1'(M_STOP - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t             state, state_nxt;
   logic [TICK_W-1:0]  tick_cnt, tick_cnt_nxt;
   logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
   logic               stop_cnt, stop_cnt_nxt;
   logic [N_DATA-1:0]  shreg, shreg_nxt;
   logic               parity, parity_nxt;
   logic               tx_nxt, busy_nxt, done_nxt;
   logic               bit_end;

   assign bit_end = i_tick && (tick_cnt == TICK_LAST);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         stop_cnt  <= 1'b0;
         shreg     <= '0;
         parity    <= 1'b0;
         o_tx      <= 1'b1;
         o_busy    <= 1'b0;
         o_tx_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         tick_cnt  <= tick_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         stop_cnt  <= stop_cnt_nxt;
         shreg     <= shreg_nxt;
         parity    <= parity_nxt;
         o_tx      <= tx_nxt;
         o_busy    <= busy_nxt;
         o_tx_done <= done_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      tick_cnt_nxt = tick_cnt;
      bit_cnt_nxt  = bit_cnt;
      stop_cnt_nxt = stop_cnt;
      shreg_nxt    = shreg;
      parity_nxt   = parity;
      done_nxt     = 1'b0;
      tx_nxt       = 1'b1;
      busy_nxt     = 1'b0;

      if (state != IDLE && i_tick) begin
         tick_cnt_nxt = bit_end ? '0 : tick_cnt + 1'b1;
      end

      case (state)
         IDLE: begin
            tick_cnt_nxt = '0;
            if (i_tx_start) begin
               shreg_nxt  = i_data;
               parity_nxt = (EVEN_ODD_PARITY != 0) ? ^i_data : ~^i_data;
               state_nxt  = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt   = DATA;
               bit_cnt_nxt = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_nxt = shreg >> 1;
               if (bit_cnt == BIT_LAST) begin
                  state_nxt    = (PARITY_CHECK != 0) ? PARITY : STOP;
                  stop_cnt_nxt = 1'b0;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_nxt    = STOP;
               stop_cnt_nxt = 1'b0;
            end
         end
         STOP: begin
            if (bit_end) begin
               stop_cnt_nxt = stop_cnt + 1'b1;
               if (stop_cnt == STOP_LAST) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Outputs are derived from the next state so the registered pins line up with the FSM.
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shreg_nxt[0];
         PARITY:  tx_nxt = parity_nxt;
         default: tx_nxt = 1'b1;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four framing variants (8N1, 8E1, 8O1, 8N2) checked sample-by-sample
// against a frame model indexed by elapsed baud ticks.
module tb_uart_tx;

   localparam int T = 16;
   localparam logic [3:0] PAR_V   = 4'b0110;
   localparam logic [3:0] EVEN_V  = 4'b1011;
   localparam logic [3:0] STOP2_V = 4'b1000;

   logic       clock = 1'b0;
   logic       reset;
   logic       tick;
   logic [3:0] start, tx, busy, done;
   logic [7:0] data [4];

   always #5 clock = ~clock;

   genvar g;
   for (g = 0; g < 4; g++) begin : g_dut
      uart_tx #(
         .N_DATA          (8),
         .PARITY_CHECK    (int'(PAR_V[g])),
         .EVEN_ODD_PARITY (int'(EVEN_V[g])),
         .M_STOP          (STOP2_V[g] ? 2 : 1),
         .TICKS_PER_BIT   (T)
      ) u_dut (
         .i_clock    (clock),
         .i_reset    (reset),
         .i_tick     (tick),
         .i_tx_start (start[g]),
         .i_data     (data[g]),
         .o_tx       (tx[g]),
         .o_busy     (busy[g]),
         .o_tx_done  (done[g])
      );
   end

   int checks = 0;
   int errors = 0;

   // One entry per sampled clock of the last capture.
   int         q_c;
   logic [2:0] q_obs [$];
   int         q_n [$];
   bit         q_tk [$];
   bit         q_idle [$];
   logic [7:0] q_d [$];

   function automatic int flen(input int c);
      return 1 + 8 + int'(PAR_V[c]) + (STOP2_V[c] ? 2 : 1);
   endfunction

   function automatic logic frame_bit(input int c, input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (k == 9 && PAR_V[c]) return EVEN_V[c] ? ^d : ~^d;
      return 1'b1;
   endfunction

   // Expected {tx, busy, done} for sample i.
   function automatic logic [2:0] expect_at(input int i);
      if (q_idle[i]) return 3'b100;
      if (q_n[i] < flen(q_c) * T) return {frame_bit(q_c, q_d[i], q_n[i] / T), 2'b10};
      return {1'b1, 1'b0, q_tk[i]};
   endfunction

   task automatic capture(input int c, input logic [7:0] d, input int div, input int poke_n,
                          input int abort_n, input bit chain_en, input logic [7:0] d2);
      int n, tail;
      bit accept, idle, poked, chain, fin, tk;
      logic [7:0] cur;
      n = 0; tail = 0; accept = 1; idle = 0; poked = 0; chain = chain_en; fin = 0; cur = d;
      q_c = c;
      q_obs.delete(); q_n.delete(); q_tk.delete(); q_idle.delete(); q_d.delete();
      @(negedge clock);
      start[c] = 1'b1; data[c] = d; tick = 1'b0;
      for (int e = 0; e < 6000 && !fin; e++) begin
         @(posedge clock);
         tk = 0;
         if (reset) idle = 1;
         else if (accept) begin n = 0; accept = 0; end
         else if (tick && !idle) begin n++; tk = 1; end
         @(negedge clock);
         start[c] = 1'b0;
         reset = 1'b0;
         q_obs.push_back({tx[c], busy[c], done[c]});
         q_n.push_back(n); q_tk.push_back(tk); q_idle.push_back(idle); q_d.push_back(cur);
         tick = ((e + 1) % div == 0);
         if (idle) begin
            tail++;
            if (tail >= 24) fin = 1;
         end else if (n == flen(c) * T) begin
            if (chain) begin
               start[c] = 1'b1; data[c] = d2; cur = d2; accept = 1; chain = 0;
            end else begin
               idle = 1;
            end
         end else begin
            if (n == poke_n && !poked) begin start[c] = 1'b1; data[c] = 8'hFF; poked = 1; end
            if (n == abort_n) reset = 1'b1;
         end
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL capture_bound: inst %0d frame never completed within cycle budget", c);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; tick = 1'b0; start = '0;
      for (int i = 0; i < 4; i++) data[i] = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({tx[i], busy[i], done[i]} !== 3'b100) begin
            errors++;
            $display("FAIL reset_hold inst %0d: tx/busy/done %b, want 100", i, {tx[i], busy[i], done[i]});
         end
      end
      reset = 1'b0; tick = 1'b1;
      repeat (5) @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({tx[i], busy[i], done[i]} !== 3'b100) begin
            errors++;
            $display("FAIL reset_idle inst %0d: tx/busy/done %b, want 100", i, {tx[i], busy[i], done[i]});
         end
      end
   endtask

   task automatic test_8n1();
      int nb, nd;
      logic [9:0] seq;
      nb = 0; nd = 0; seq = 10'b1101001010;
      capture(0, 8'hA5, 1, -1, -1, 0, 8'h00);
      for (int i = 0; i < q_obs.size(); i++) begin
         checks++;
         if (q_obs[i] !== expect_at(i)) begin
            errors++;
            $display("FAIL 8n1 sample %0d: tx/busy/done %b, want %b", i, q_obs[i], expect_at(i));
         end
         nb += int'(q_obs[i][1]);
         nd += int'(q_obs[i][0]);
      end
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (q_obs[k*T+8][2] !== seq[k]) begin
            errors++;
            $display("FAIL 8n1_bit %0d: tx %b, want %b", k, q_obs[k*T+8][2], seq[k]);
         end
      end
      checks++;
      if (nb !== 160) begin errors++; $display("FAIL 8n1_busy_len: %0d clocks, want 160", nb); end
      checks++;
      if (nd !== 1) begin errors++; $display("FAIL 8n1_done_count: %0d pulses, want 1", nd); end
   endtask

   task automatic test_parity();
      int nb;
      for (int c = 1; c <= 2; c++) begin
         nb = 0;
         capture(c, 8'hA5, 1, -1, -1, 0, 8'h00);
         for (int i = 0; i < q_obs.size(); i++) begin
            checks++;
            if (q_obs[i] !== expect_at(i)) begin
               errors++;
               $display("FAIL parity inst %0d sample %0d: tx/busy/done %b, want %b", c, i, q_obs[i], expect_at(i));
            end
            nb += int'(q_obs[i][1]);
         end
         checks++;
         if (q_obs[9*T+8][2] !== (c == 1 ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL parity_bit inst %0d: tx %b, want %b", c, q_obs[9*T+8][2], (c == 1 ? 1'b0 : 1'b1));
         end
         checks++;
         if (nb !== 176) begin errors++; $display("FAIL parity_len inst %0d: %0d clocks, want 176", c, nb); end
      end
   endtask

   task automatic test_two_stop();
      int nlow, nhigh;
      nlow = 0; nhigh = 0;
      capture(3, 8'h00, 1, -1, -1, 0, 8'h00);
      for (int i = 0; i < q_obs.size(); i++) begin
         checks++;
         if (q_obs[i] !== expect_at(i)) begin
            errors++;
            $display("FAIL two_stop sample %0d: tx/busy/done %b, want %b", i, q_obs[i], expect_at(i));
         end
         if (q_obs[i][1] === 1'b1 && q_obs[i][2] === 1'b0) nlow++;
         if (q_obs[i][1] === 1'b1 && q_obs[i][2] === 1'b1) nhigh++;
      end
      checks++;
      if (nlow !== 144) begin errors++; $display("FAIL two_stop_low: %0d clocks, want 144", nlow); end
      checks++;
      if (nhigh !== 32) begin errors++; $display("FAIL two_stop_high: %0d clocks, want 32", nhigh); end
   endtask

   task automatic test_busy_ignore();
      int nd;
      nd = 0;
      capture(0, 8'h3C, 1, 50, -1, 0, 8'h00);
      for (int i = 0; i < q_obs.size(); i++) begin
         checks++;
         if (q_obs[i] !== expect_at(i)) begin
            errors++;
            $display("FAIL busy_ignore sample %0d: tx/busy/done %b, want %b", i, q_obs[i], expect_at(i));
         end
         nd += int'(q_obs[i][0]);
      end
      checks++;
      if (nd !== 1) begin errors++; $display("FAIL busy_ignore_done: %0d pulses, want 1", nd); end
   endtask

   task automatic test_back_to_back();
      int nd;
      nd = 0;
      capture(0, 8'h3C, 1, 50, -1, 1, 8'h81);
      for (int i = 0; i < q_obs.size(); i++) begin
         checks++;
         if (q_obs[i] !== expect_at(i)) begin
            errors++;
            $display("FAIL back_to_back sample %0d: tx/busy/done %b, want %b", i, q_obs[i], expect_at(i));
         end
         nd += int'(q_obs[i][0]);
      end
      checks++;
      if (q_obs[161] !== 3'b010) begin
         errors++;
         $display("FAIL b2b_start_bit: tx/busy/done %b, want 010", q_obs[161]);
      end
      checks++;
      if (nd !== 2) begin errors++; $display("FAIL b2b_done_count: %0d pulses, want 2", nd); end
   endtask

   task automatic test_slow_tick_reset();
      int nb, nd;
      nb = 0;
      capture(0, 8'h55, 4, -1, -1, 0, 8'h00);
      for (int i = 0; i < q_obs.size(); i++) begin
         checks++;
         if (q_obs[i] !== expect_at(i)) begin
            errors++;
            $display("FAIL slow_tick sample %0d: tx/busy/done %b, want %b", i, q_obs[i], expect_at(i));
         end
         nb += int'(q_obs[i][1]);
      end
      checks++;
      if (nb !== 640) begin errors++; $display("FAIL slow_tick_len: %0d clocks, want 640", nb); end
      nd = 0;
      capture(0, 8'h55, 4, -1, 70, 0, 8'h00);
      for (int i = 0; i < q_obs.size(); i++) begin
         checks++;
         if (q_obs[i] !== expect_at(i)) begin
            errors++;
            $display("FAIL abort sample %0d: tx/busy/done %b, want %b", i, q_obs[i], expect_at(i));
         end
         nd += int'(q_obs[i][0]);
      end
      checks++;
      if (nd !== 0) begin errors++; $display("FAIL abort_done: %0d pulses, want 0", nd); end
      capture(0, 8'h12, 1, -1, -1, 0, 8'h00);
      for (int i = 0; i < q_obs.size(); i++) begin
         checks++;
         if (q_obs[i] !== expect_at(i)) begin
            errors++;
            $display("FAIL after_abort sample %0d: tx/busy/done %b, want %b", i, q_obs[i], expect_at(i));
         end
      end
   endtask

   task automatic test_random();
      int c, div, poke;
      bit chain;
      logic [7:0] d, d2;
      for (int r = 0; r < 12; r++) begin
         c     = $urandom_range(0, 3);
         d     = 8'($urandom);
         d2    = 8'($urandom);
         div   = $urandom_range(1, 4);
         poke  = $urandom_range(0, 200);
         chain = 1'($urandom_range(0, 1));
         capture(c, d, div, poke, -1, chain, d2);
         for (int i = 0; i < q_obs.size(); i++) begin
            checks++;
            if (q_obs[i] !== expect_at(i)) begin
               errors++;
               $display("FAIL random run %0d inst %0d data %h sample %0d: tx/busy/done %b, want %b",
                        r, c, q_d[i], i, q_obs[i], expect_at(i));
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      tick  = 1'b0;
      start = '0;
      for (int i = 0; i < 4; i++) data[i] = '0;
      test_reset();
      test_8n1();
      test_parity();
      test_two_stop();
      test_busy_ignore();
      test_back_to_back();
      test_slow_tick_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
